// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter (inhibit, start, 8 data, odd parity, stop, ack)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX      = '1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;

  logic          clk_s1;
  logic          clk_s2;
  logic          clk_prev;
  logic          data_s1;
  logic          data_s2;
  logic          fall;

  logic [2:0]    state;
  logic [9:0]    frame;
  logic [3:0]    bit_idx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  // Idle-high reset values keep a released bus from looking like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall    = clk_prev & ~clk_s2;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      frame       <= '0;
      bit_idx     <= '0;
      cnt         <= '0;
      tx_ready    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          // tx_ready is still low on the tx_done cycle, so it rises one cycle later.
          if (tx_valid && tx_ready) begin
            frame      <= {1'b1, ~^tx_data, tx_data};
            cnt        <= '0;
            bit_idx    <= '0;
            tx_ready   <= 1'b0;
            ps2_clk_oe <= 1'b1;
            state      <= ST_INHIBIT;
          end else begin
            tx_ready <= 1'b1;
          end
        end

        ST_INHIBIT: begin
          if (cnt == INHIBIT_LAST) begin
            ps2_data_oe <= 1'b1;
            state       <= ST_REQ;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_REQ: begin
          ps2_clk_oe <= 1'b0;
          bit_idx    <= '0;
          cnt        <= '0;
          state      <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (fall) begin
            ps2_data_oe <= ~frame[bit_idx];
            cnt         <= '0;
            bit_idx     <= bit_idx + 1'b1;
            if (bit_idx == 4'd9) begin
              state <= ST_ACK;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b1;
            tx_err      <= 1'b1;
            cnt         <= '0;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_ACK: begin
          if (fall) begin
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b1;
            tx_err      <= data_s2;
            cnt         <= '0;
            state       <= ST_IDLE;
          end else if (cnt == TIMEOUT_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b1;
            tx_err      <= 1'b1;
            cnt         <= '0;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_ready    <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed-vector bench for ps2_host_tx with a simple PS/2 device model
`timescale 1ns/1ps
module tb_ps2_host_tx;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_done;
  logic       tx_err;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk;
  logic       ps2_data;

  assign ps2_clk  = ps2_clk_oe  ? 1'b0 : dev_clk;
  assign ps2_data = ps2_data_oe ? 1'b0 : dev_data;

  int   n_vec    = 0;
  int   n_miss   = 0;
  int   done_cnt = 0;
  logic last_err;
  logic done_ready;
  logic after_ready;
  logic prev_done = 1'b0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    prev_done <= tx_done;
    if (prev_done) after_ready <= tx_ready;
    if (tx_done) begin
      done_cnt   <= done_cnt + 1;
      last_err   <= tx_err;
      done_ready <= tx_ready;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    while (!tx_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_send", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'hA5;
  endtask

  // Entered on the first INHIBIT sample; leaves on the first SHIFT sample.
  task automatic check_preamble();
    int n;
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("inhibit_len", n, 20);
    chk("req_clk_oe", ps2_clk_oe, 1);
    chk("req_data_oe", ps2_data_oe, 1);
    @(negedge clk);
    chk("shift_clk_oe", ps2_clk_oe, 0);
    chk("start_bit_oe", ps2_data_oe, 1);
  endtask

  // Device clocks at 1/40 clk; samples the line just before each rising edge.
  task automatic dev_frame(input logic ack_level, input bit inject, input int nfalls,
                           output logic [9:0] seen);
    seen = '0;
    for (int k = 0; k < nfalls; k++) begin
      if (k == 10) dev_data = ack_level;
      repeat (20) @(negedge clk);
      dev_clk = 1'b0;
      if (inject && k == 3) begin
        repeat (5) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h12;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (14) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      if (k < 10) seen[k] = ps2_data;
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
  endtask

  task automatic run_frame(input string name, input logic [7:0] b, input logic par,
                           input logic ack_level, input bit inject);
    logic [9:0] seen;
    int d0;
    d0 = done_cnt;
    send(b);
    check_preamble();
    dev_frame(ack_level, inject, 11, seen);
    repeat (5) @(negedge clk);
    chk({name, "_bits"}, 32'(seen), 32'({1'b1, par, b}));
    chk({name, "_done_cnt"}, done_cnt - d0, 1);
    chk({name, "_err"}, last_err, ack_level);
    chk({name, "_ready_at_done"}, done_ready, 0);
    chk({name, "_ready_after"}, after_ready, 1);
  endtask

  initial begin
    logic [9:0] seen;
    int n;
    int d0;

    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);
    chk("rst_ready", tx_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", tx_ready, 1);

    run_frame("ed", 8'hED, 1'b1, 1'b0, 0);
    run_frame("x00", 8'h00, 1'b1, 1'b0, 0);
    run_frame("x01", 8'h01, 1'b0, 1'b0, 0);
    run_frame("ff_nack", 8'hFF, 1'b1, 1'b1, 0);

    d0 = done_cnt;
    send(8'hF4);
    check_preamble();
    n = 0;
    while (!tx_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, 100);
    chk("to_done", tx_done, 1);
    chk("to_err", tx_err, 1);
    chk("to_clk_oe", ps2_clk_oe, 0);
    chk("to_data_oe", ps2_data_oe, 0);
    @(negedge clk);
    chk("to_ready_after", tx_ready, 1);
    chk("to_done_cnt", done_cnt - d0, 1);

    send(8'hED);
    check_preamble();
    dev_frame(1'b0, 0, 4, seen);
    chk("abort_low_nibble", 32'(seen[3:0]), 32'h0000000D);
    repeat (20) @(negedge clk);
    dev_clk = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_bit4_oe", ps2_data_oe, 1);
    d0 = done_cnt;
    #1 rst = 1'b1;
    #1;
    chk("abort_clk_oe", ps2_clk_oe, 0);
    chk("abort_data_oe", ps2_data_oe, 0);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_ready_in_rst", tx_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", tx_ready, 1);
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);

    run_frame("ed_fresh", 8'hED, 1'b1, 1'b0, 0);

    run_frame("ed_inject", 8'hED, 1'b1, 1'b0, 1);
    repeat (40) @(negedge clk);
    chk("inject_not_queued", ps2_clk_oe, 0);
    chk("inject_idle_ready", tx_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
